rv_decode_queue: RTL and testbench

RV_DECODE_QUEUE -- requirements
Module: rv_decode_queue

---
 rtl/rv_decode_pkg.sv | 86 ++++++++
 rtl/rv_insn_decode.sv | 98 +++++++++
 rtl/rv_decode_queue.sv | 123 ++++++++++++
 tb/tb_rv_decode_queue.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_decode_pkg.sv
// Shared types for the RV32 decode queue: format codes, per-format field
// layouts of a raw instruction word, and the supported major opcodes.
package rv_decode_pkg;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ILL = 3'd7
   } fmt_t;

   typedef struct packed {
      logic [6:0] func7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] func3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } R_t;

   typedef struct packed {
      logic [11:0] imm;
      logic [4:0]  rs1;
      logic [2:0]  func3;
      logic [4:0]  rd;
      logic [6:0]  opcode;
   } I_t;

   typedef struct packed {
      logic [6:0] imm_hi;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] func3;
      logic [4:0] imm_lo;
      logic [6:0] opcode;
   } S_t;

   typedef struct packed {
      logic       imm12;
      logic [5:0] imm10_5;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] func3;
      logic [3:0] imm4_1;
      logic       imm11;
      logic [6:0] opcode;
   } B_t;

   typedef struct packed {
      logic [19:0] imm;
      logic [4:0]  rd;
      logic [6:0]  opcode;
   } U_t;

   typedef struct packed {
      logic       imm20;
      logic [9:0] imm10_1;
      logic       imm11;
      logic [7:0] imm19_12;
      logic [4:0] rd;
      logic [6:0] opcode;
   } J_t;

   typedef union packed {
      R_t r;
      I_t i;
      S_t s;
      B_t b;
      U_t u;
      J_t j;
   } instruction_t;

   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_REG    = 7'h33;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JAL    = 7'h6F;

endpackage

// File: rtl/rv_insn_decode.sv
// Purely combinational RV32 instruction decoder.
// Ports:
//   insn     - raw 32-bit instruction word
//   fmt      - decoded format (FMT_ILL for unsupported opcodes)
//   opcode   - insn[6:0], always passed through
//   rd, rs1, rs2, func3, func7 - register/function fields, zeroed where
//              the format does not define them
//   imm      - immediate sign-extended to XLEN
//   illegal  - opcode is not one of the supported majors
module rv_insn_decode
   import rv_decode_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]     insn,
   output fmt_t            fmt,
   output logic [6:0]      opcode,
   output logic [4:0]      rd,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [2:0]      func3,
   output logic [6:0]      func7,
   output logic [XLEN-1:0] imm,
   output logic            illegal
);

   instruction_t ins;
   logic [31:0]  imm32;

   assign ins    = insn;
   assign opcode = insn[6:0];

   // All immediates are at most 32 bits wide; build them sign-extended to
   // 32 and widen once at the end so XLEN=32 needs no zero-width replicate.
   assign imm = XLEN'($signed(imm32));

   always_comb begin
      fmt     = FMT_ILL;
      illegal = 1'b1;
      rd      = '0;
      rs1     = '0;
      rs2     = '0;
      func3   = '0;
      func7   = '0;
      imm32   = '0;
      case (ins.r.opcode)
         OP_LUI, OP_AUIPC: begin
            fmt     = FMT_U;
            illegal = 1'b0;
            rd      = ins.u.rd;
            imm32   = {ins.u.imm, 12'b0};
         end
         OP_IMM, OP_LOAD, OP_JALR: begin
            fmt     = FMT_I;
            illegal = 1'b0;
            rd      = ins.i.rd;
            rs1     = ins.i.rs1;
            func3   = ins.i.func3;
            imm32   = {{20{ins.i.imm[11]}}, ins.i.imm};
         end
         OP_REG: begin
            fmt     = FMT_R;
            illegal = 1'b0;
            rd      = ins.r.rd;
            rs1     = ins.r.rs1;
            rs2     = ins.r.rs2;
            func3   = ins.r.func3;
            func7   = ins.r.func7;
         end
         OP_STORE: begin
            fmt     = FMT_S;
            illegal = 1'b0;
            rs1     = ins.s.rs1;
            rs2     = ins.s.rs2;
            func3   = ins.s.func3;
            imm32   = {{20{ins.s.imm_hi[6]}}, ins.s.imm_hi, ins.s.imm_lo};
         end
         OP_BRANCH: begin
            fmt     = FMT_B;
            illegal = 1'b0;
            rs1     = ins.b.rs1;
            rs2     = ins.b.rs2;
            func3   = ins.b.func3;
            imm32   = {{19{ins.b.imm12}}, ins.b.imm12, ins.b.imm11,
                       ins.b.imm10_5, ins.b.imm4_1, 1'b0};
         end
         OP_JAL: begin
            fmt     = FMT_J;
            illegal = 1'b0;
            rd      = ins.j.rd;
            imm32   = {{11{ins.j.imm20}}, ins.j.imm20, ins.j.imm19_12,
                       ins.j.imm11, ins.j.imm10_1, 1'b0};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/rv_decode_queue.sv
// Decode-then-queue stage: words are decoded combinationally on entry and
// the decoded entries are held in a DEPTH-deep FIFO (latency 1, no bypass).
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   in_valid/in_ready/in_insn - instruction word input handshake
//   out_valid/out_ready      - decoded head entry handshake
//   out_fmt .. out_illegal   - decoded fields of the head (0 when empty)
//   count                    - current occupancy
module rv_decode_queue
   import rv_decode_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_insn,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2:0]               out_fmt,
   output logic [6:0]               out_opcode,
   output logic [4:0]               out_rd,
   output logic [4:0]               out_rs1,
   output logic [4:0]               out_rs2,
   output logic [2:0]               out_func3,
   output logic [6:0]               out_func7,
   output logic [XLEN-1:0]          out_imm,
   output logic                     out_illegal,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      fmt_t            fmt;
      logic [6:0]      opcode;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      func3;
      logic [6:0]      func7;
      logic [XLEN-1:0] imm;
      logic            illegal;
   } entry_t;

   entry_t           mem [DEPTH];
   entry_t           dec;
   entry_t           head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;

   rv_insn_decode #(.XLEN(XLEN)) u_decode (
      .insn    (in_insn),
      .fmt     (dec.fmt),
      .opcode  (dec.opcode),
      .rd      (dec.rd),
      .rs1     (dec.rs1),
      .rs2     (dec.rs2),
      .func3   (dec.func3),
      .func7   (dec.func7),
      .imm     (dec.imm),
      .illegal (dec.illegal)
   );

   assign in_ready  = (count != CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign head      = mem[rd_ptr];

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem[wr_ptr] <= dec;
      end
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   always_comb begin
      out_fmt     = '0;
      out_opcode  = '0;
      out_rd      = '0;
      out_rs1     = '0;
      out_rs2     = '0;
      out_func3   = '0;
      out_func7   = '0;
      out_imm     = '0;
      out_illegal = 1'b0;
      if (out_valid) begin
         out_fmt     = head.fmt;
         out_opcode  = head.opcode;
         out_rd      = head.rd;
         out_rs1     = head.rs1;
         out_rs2     = head.rs2;
         out_func3   = head.func3;
         out_func7   = head.func7;
         out_imm     = head.imm;
         out_illegal = head.illegal;
      end
   end

endmodule

// File: tb/tb_rv_decode_queue.sv
// Bench for rv_decode_queue: one XLEN=32/DEPTH=2 instance and one
// XLEN=64/DEPTH=4 instance share the same stimulus; each is compared
// against its own queue-of-words reference with an arithmetic decoder.
module tb_rv_decode_queue;

   typedef struct packed {
      logic [2:0]  fmt;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  func3;
      logic [6:0]  func7;
      logic        illegal;
      logic [63:0] imm;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_insn;
   logic        out_ready;

   logic        a_in_ready, a_out_valid, a_illegal;
   logic [2:0]  a_fmt, a_func3;
   logic [6:0]  a_opcode, a_func7;
   logic [4:0]  a_rd, a_rs1, a_rs2;
   logic [31:0] a_imm;
   logic [1:0]  a_count;

   logic        b_in_ready, b_out_valid, b_illegal;
   logic [2:0]  b_fmt, b_func3;
   logic [6:0]  b_opcode, b_func7;
   logic [4:0]  b_rd, b_rs1, b_rs2;
   logic [63:0] b_imm;
   logic [2:0]  b_count;

   int unsigned total = 0;
   int unsigned bad   = 0;

   logic [31:0] q0[$];
   logic [31:0] q1[$];

   always #5 clk = ~clk;

   rv_decode_queue #(.XLEN(32), .DEPTH(2)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_insn(in_insn), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_fmt(a_fmt), .out_opcode(a_opcode), .out_rd(a_rd), .out_rs1(a_rs1),
      .out_rs2(a_rs2), .out_func3(a_func3), .out_func7(a_func7),
      .out_imm(a_imm), .out_illegal(a_illegal), .count(a_count)
   );

   rv_decode_queue #(.XLEN(64), .DEPTH(4)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_insn(in_insn), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_fmt(b_fmt), .out_opcode(b_opcode), .out_rd(b_rd), .out_rs1(b_rs1),
      .out_rs2(b_rs2), .out_func3(b_func3), .out_func7(b_func7),
      .out_imm(b_imm), .out_illegal(b_illegal), .count(b_count)
   );

   task automatic check_val(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference decode built from integer arithmetic on the word.
   function automatic exp_t ref_decode(input logic [31:0] w);
      exp_t e;
      int sx, hi, v;
      logic [31:0] vb;
      e = '0;
      e.opcode = w[6:0];
      sx = int'(w);
      hi = sx >>> 31;
      v  = 0;
      case (w[6:0])
         7'h37, 7'h17: begin
            e.fmt = 3'd4; e.rd = w[11:7];
            v = sx - int'(w[11:0]);
         end
         7'h13, 7'h03, 7'h67: begin
            e.fmt = 3'd1; e.rd = w[11:7]; e.rs1 = w[19:15]; e.func3 = w[14:12];
            v = sx >>> 20;
         end
         7'h33: begin
            e.fmt = 3'd0; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
            e.func3 = w[14:12]; e.func7 = w[31:25];
         end
         7'h23: begin
            e.fmt = 3'd2; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.func3 = w[14:12];
            v = (sx >>> 25) * 32 + int'(w[11:7]);
         end
         7'h63: begin
            e.fmt = 3'd3; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.func3 = w[14:12];
            v = hi * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                + int'(w[11:8]) * 2;
         end
         7'h6F: begin
            e.fmt = 3'd5; e.rd = w[11:7];
            v = hi * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                + int'(w[30:21]) * 2;
         end
         default: begin
            e.fmt = 3'd7; e.illegal = 1'b1;
         end
      endcase
      vb = v;
      e.imm = {{32{vb[31]}}, vb};
      return e;
   endfunction

   task automatic check_inst(input int k);
      exp_t e;
      int n, dep;
      string p;
      logic [63:0] eimm, gimm;
      e = '0;
      if (k == 0) begin
         p = "a."; dep = 2; n = q0.size();
         if (n != 0) e = ref_decode(q0[0]);
         eimm = {32'b0, e.imm[31:0]};
         gimm = {32'b0, a_imm};
         check_val({p, "count"},     64'(a_count),     64'(n));
         check_val({p, "in_ready"},  64'(a_in_ready),  64'(n != dep));
         check_val({p, "out_valid"}, 64'(a_out_valid), 64'(n != 0));
         check_val({p, "fmt"},       64'(a_fmt),       64'(e.fmt));
         check_val({p, "opcode"},    64'(a_opcode),    64'(e.opcode));
         check_val({p, "rd"},        64'(a_rd),        64'(e.rd));
         check_val({p, "rs1"},       64'(a_rs1),       64'(e.rs1));
         check_val({p, "rs2"},       64'(a_rs2),       64'(e.rs2));
         check_val({p, "func3"},     64'(a_func3),     64'(e.func3));
         check_val({p, "func7"},     64'(a_func7),     64'(e.func7));
         check_val({p, "illegal"},   64'(a_illegal),   64'(e.illegal));
         check_val({p, "imm"},       gimm,             eimm);
      end else begin
         p = "b."; dep = 4; n = q1.size();
         if (n != 0) e = ref_decode(q1[0]);
         check_val({p, "count"},     64'(b_count),     64'(n));
         check_val({p, "in_ready"},  64'(b_in_ready),  64'(n != dep));
         check_val({p, "out_valid"}, 64'(b_out_valid), 64'(n != 0));
         check_val({p, "fmt"},       64'(b_fmt),       64'(e.fmt));
         check_val({p, "opcode"},    64'(b_opcode),    64'(e.opcode));
         check_val({p, "rd"},        64'(b_rd),        64'(e.rd));
         check_val({p, "rs1"},       64'(b_rs1),       64'(e.rs1));
         check_val({p, "rs2"},       64'(b_rs2),       64'(e.rs2));
         check_val({p, "func3"},     64'(b_func3),     64'(e.func3));
         check_val({p, "func7"},     64'(b_func7),     64'(e.func7));
         check_val({p, "illegal"},   64'(b_illegal),   64'(e.illegal));
         check_val({p, "imm"},       b_imm,            e.imm);
      end
   endtask

   // Drive one cycle from a falling edge, advance the model at the rising
   // edge, then compare both instances at the next falling edge.
   task automatic step(input logic v, input logic [31:0] w,
                       input logic ordy, input logic r);
      bit pop0, push0, pop1, push1;
      in_valid = v; in_insn = w; out_ready = ordy; rst = r;
      pop0  = (q0.size() != 0) && ordy;
      push0 = v && (q0.size() != 2);
      pop1  = (q1.size() != 0) && ordy;
      push1 = v && (q1.size() != 4);
      @(posedge clk);
      if (r) begin
         q0.delete(); q1.delete();
      end else begin
         if (pop0)  void'(q0.pop_front());
         if (push0) q0.push_back(w);
         if (pop1)  void'(q1.pop_front());
         if (push1) q1.push_back(w);
      end
      @(negedge clk);
      check_inst(0);
      check_inst(1);
   endtask

   logic [6:0] op_tab [10] = '{7'h37, 7'h17, 7'h13, 7'h03, 7'h67,
                                7'h33, 7'h23, 7'h63, 7'h6F, 7'h0B};

   initial begin
      logic [31:0] w;
      rst = 1'b1; in_valid = 1'b0; in_insn = '0; out_ready = 1'b0;
      @(negedge clk);
      step(1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b1);
      check_val("rst.in_ready", 64'(a_in_ready), 64'd1);

      // LUI x29
      step(1'b1, 32'h0AA01EB7, 1'b0, 1'b0);
      check_val("lui.fmt", 64'(a_fmt), 64'd4);
      check_val("lui.opcode", 64'(a_opcode), 64'h37);
      check_val("lui.rd", 64'(a_rd), 64'd29);
      check_val("lui.imm", 64'(a_imm), 64'h0AA01000);
      check_val("lui.rs1", 64'(a_rs1), 64'd0);
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // addi x1,x0,-1
      step(1'b1, 32'hFFF00093, 1'b0, 1'b0);
      check_val("addi.fmt", 64'(b_fmt), 64'd1);
      check_val("addi.rd", 64'(b_rd), 64'd1);
      check_val("addi.imm", b_imm, 64'hFFFFFFFFFFFFFFFF);
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // beq x0,x0,-4
      step(1'b1, 32'hFE000EE3, 1'b0, 1'b0);
      check_val("beq.fmt", 64'(a_fmt), 64'd3);
      check_val("beq.imm", 64'(a_imm), 64'hFFFFFFFC);
      check_val("beq.rd", 64'(a_rd), 64'd0);
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // unsupported opcode
      step(1'b1, 32'h0000000B, 1'b0, 1'b0);
      check_val("ill.flag", 64'(a_illegal), 64'd1);
      check_val("ill.fmt", 64'(a_fmt), 64'd7);
      check_val("ill.imm", 64'(a_imm), 64'd0);
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // fill with consumer stalled, then drain
      step(1'b1, 32'h00208033, 1'b0, 1'b0);
      step(1'b1, 32'h0041A223, 1'b0, 1'b0);
      check_val("full.in_ready", 64'(a_in_ready), 64'd0);
      step(1'b1, 32'h8000006F, 1'b0, 1'b0);
      check_val("full.count", 64'(a_count), 64'd2);
      check_val("full.head_op", 64'(a_opcode), 64'h33);
      for (int unsigned i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
      check_val("drain.count", 64'(a_count), 64'd0);

      // reset with entries queued and a word offered
      step(1'b1, 32'h00500513, 1'b0, 1'b0);
      step(1'b1, 32'h00C00593, 1'b0, 1'b0);
      check_val("pre_rst.count", 64'(a_count), 64'd2);
      step(1'b1, 32'h00100613, 1'b1, 1'b1);
      check_val("rst_mid.count", 64'(a_count), 64'd0);
      check_val("rst_mid.out_valid", 64'(a_out_valid), 64'd0);
      check_val("rst_mid.in_ready", 64'(a_in_ready), 64'd1);
      check_val("rst_mid.b_count", 64'(b_count), 64'd0);

      for (int unsigned i = 0; i < 600; i++) begin
         w = $urandom();
         if ($urandom_range(0, 9) != 0) w[6:0] = op_tab[$urandom_range(0, 9)];
         step(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 59) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
